// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter and byte sequencer sharing one UART TX bit engine among
// NREQ byte sources. A granted source keeps ownership for up to BURST bytes or
// until it flags its last byte. One tx_start pulse is issued per byte, and the
// next byte is accepted only after the transmitter's busy window has closed.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   BURST    maximum bytes per grant (1..15)
//   TIMEOUT  idle-owner release limit in clk cycles (used with the macro below)
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   req_valid    [NREQ]    requester i presents a byte
//   req_data     [8*NREQ]  byte of requester i on [8i+7:8i]
//   req_last     [NREQ]    presented byte ends its message
//   req_ready    [NREQ]    one-hot accept strobe (valid & ready = accepted)
//   grant        [NREQ]    one-hot current owner, 0 when idle
//   grant_id     [3]       binary owner index, 0 when idle
//   tx_start     one-cycle start pulse to the UART TX
//   tx_data      [8]       byte to send, held until the next accepted byte
//   tx_busy      UART TX frame in progress
//   timeout_err  one-cycle pulse when an idle owner is forcibly released
//
// Build option:
//   UART_ARB_TIMEOUT_EN  when defined, an owner that presents no byte for
//                        TIMEOUT cycles in GRANT loses its grant. When
//                        undefined, no counter exists and timeout_err is 0.
//
// State table:
//   S_IDLE      | no owner; pick next requester round-robin from ptr
//   S_GRANT     | owner holds grant; ready only while tx_busy is low
//   S_ISSUE     | tx_start pulse for the byte just accepted
//   S_WAIT_ACK  | waiting for the UART to raise tx_busy
//   S_WAIT_DONE | waiting for tx_busy to fall; then next byte or release
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 12500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [2:0]        grant_id,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [2:0] ptr;
  logic [3:0] byte_cnt;
  logic       last_flag;

  // Requester signals widened to 8 entries so a 3-bit index always fits
  // exactly, whatever NREQ is.
  logic [7:0] valid_ext;
  logic [7:0] last_ext;
  logic [7:0] data_arr [8];

  always_comb begin
    valid_ext = '0;
    last_ext  = '0;
    for (int i = 0; i < 8; i++) data_arr[i] = '0;
    for (int i = 0; i < NREQ; i++) begin
      valid_ext[i] = req_valid[i];
      last_ext[i]  = req_last[i];
      data_arr[i]  = req_data[8*i +: 8];
    end
  end

  // Round-robin pick: first valid requester at or above ptr, wrapping.
  logic            pick_found;
  logic [2:0]      pick_id;
  logic [3:0]      cand;
  logic [NREQ-1:0] pick_onehot;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!pick_found && valid_ext[cand[2:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[2:0];
      end
    end
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_onehot[i] = pick_found && (pick_id == 3'(i));
    end
  end

  logic       own_valid;
  logic       own_last;
  logic [7:0] own_data;
  logic       accept;
  logic       burst_end;
  logic       frame_done;
  logic       timeout_hit;
  logic       release_grant;

  assign own_valid  = valid_ext[grant_id];
  assign own_last   = last_ext[grant_id];
  assign own_data   = data_arr[grant_id];
  assign accept     = (state == S_GRANT) && own_valid && !tx_busy;
  assign burst_end  = last_flag || (byte_cnt == 4'(BURST - 1));
  assign frame_done = (state == S_WAIT_DONE) && !tx_busy;

  assign release_grant = (frame_done && burst_end) || timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  // Counts GRANT cycles in which the owner presents nothing; held at zero
  // outside GRANT so every entry into GRANT starts a fresh window.
  logic [13:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (state != S_GRANT) begin
      idle_cnt <= '0;
    end else if (!own_valid) begin
      idle_cnt <= idle_cnt + 14'd1;
    end
  end

  assign timeout_hit = (state == S_GRANT) && !own_valid &&
                       (idle_cnt == 14'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  assign timeout_err = timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_start  = 1'b0;
    req_ready = '0;
    case (state)
      S_IDLE: begin
        if (pick_found) state_nxt = S_GRANT;
      end
      S_GRANT: begin
        // Ready is gated by tx_busy so a frame still in flight after a reset
        // can never be overlapped.
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = (grant_id == 3'(i)) && !tx_busy;
        end
        if (accept)           state_nxt = S_ISSUE;
        else if (timeout_hit) state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        tx_start  = 1'b1;
        state_nxt = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!tx_busy) state_nxt = burst_end ? S_IDLE : S_GRANT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant     <= '0;
      grant_id  <= '0;
      tx_data   <= 8'h00;
      ptr       <= '0;
      byte_cnt  <= '0;
      last_flag <= 1'b0;
    end else begin
      if ((state == S_IDLE) && pick_found) begin
        grant    <= pick_onehot;
        grant_id <= pick_id;
        byte_cnt <= '0;
      end
      if (accept) begin
        tx_data   <= own_data;
        last_flag <= own_last;
      end
      if (frame_done && !burst_end) begin
        byte_cnt <= byte_cnt + 4'd1;
      end
      if (release_grant) begin
        grant    <= '0;
        grant_id <= '0;
        // Previous owner drops to lowest priority on the next pick.
        ptr      <= (grant_id == 3'(NREQ - 1)) ? 3'd0 : grant_id + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [2:0]        grant_id;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;
  logic              timeout_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .grant(grant), .grant_id(grant_id),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Source message storage, consumed by the driver on valid&ready.
  logic [7:0] src_data [NREQ][64];
  bit         src_last [NREQ][64];
  int         wr_n [NREQ];
  int         rd_n [NREQ];

  // Reference stream of (owner, byte) in transmit order.
  int         exp_owner [$];
  logic [7:0] exp_byte  [$];
  int         owner_log [$];
  int         m_ptr;

  int         busy_fixed;
  int         busy_left;
  logic [7:0] held_data;
  bit         skip_hold;
  int         n_starts;
  int         to_seen;

  task automatic push_byte(input int r, input logic [7:0] d, input bit l);
    src_data[r][wr_n[r]] = d;
    src_last[r][wr_n[r]] = l;
    wr_n[r]++;
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < NREQ; i++) begin
      wr_n[i] = 0;
      rd_n[i] = 0;
    end
    exp_owner.delete();
    exp_byte.delete();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (rd_n[i] < wr_n[i]) p = 1'b1;
    return p;
  endfunction

  // Behavioural arbitration over the loaded messages: pick the first
  // non-empty source from m_ptr, send until last or BURST bytes, rotate.
  task automatic build_expected();
    int m_rd [NREQ];
    int owner;
    int cnt;
    int c;
    bit done;
    bit stalled;
    for (int i = 0; i < NREQ; i++) m_rd[i] = rd_n[i];
    stalled = 1'b0;
    while (!stalled) begin
      owner = -1;
      for (int k = 0; k < NREQ; k++) begin
        c = (m_ptr + k) % NREQ;
        if (owner < 0 && m_rd[c] < wr_n[c]) owner = c;
      end
      if (owner < 0) break;
      cnt = 0;
      forever begin
        exp_owner.push_back(owner);
        exp_byte.push_back(src_data[owner][m_rd[owner]]);
        done = src_last[owner][m_rd[owner]] || (cnt == BURST - 1);
        m_rd[owner]++;
        if (done) break;
        cnt++;
        if (m_rd[owner] >= wr_n[owner]) begin
          stalled = 1'b1;
          break;
        end
      end
      if (!stalled) m_ptr = (owner + 1) % NREQ;
    end
  endtask

  // One clock: UART model and checks at negedge, then source drive, then
  // handshake bookkeeping just before the next posedge.
  task automatic tick();
    int eo;
    logic [7:0] eb;
    @(negedge clk);
    if (tx_start) begin
      n_starts++;
      owner_log.push_back(int'(grant_id));
      if (exp_owner.size() == 0) begin
        chk("start_unexpected", {24'b0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        eo = exp_owner.pop_front();
        eb = exp_byte.pop_front();
        chk("tx_data", tx_data, eb);
        chk("grant_id", grant_id, eo);
        chk("grant", grant, 1 << eo);
      end
      held_data = tx_data;
      skip_hold = 1'b0;
      busy_left = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(2, 6));
      tx_busy   = 1'b1;
    end else if (busy_left > 0) begin
      if (!skip_hold) chk("tx_data_hold", tx_data, held_data);
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (timeout_err) to_seen++;
    for (int i = 0; i < NREQ; i++) begin
      if (rd_n[i] < wr_n[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_data[i][rd_n[i]];
        req_last[i]        = src_last[i][rd_n[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    #1;
    chk("ready_onehot", 32'($onehot0(req_ready)), 1);
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) rd_n[i]++;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while ((exp_owner.size() != 0 || tx_busy || grant != '0 || pending()) && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_in_budget"}, 32'(k < budget), 1);
    chk({tag, "_grant_idle"}, grant, 0);
    chk({tag, "_all_sent"}, exp_owner.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    clear_srcs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_ptr = 0;
    skip_hold = 1'b1;
  endtask

  initial begin
    int s0;
    int k;
    int nmsg;
    int len;

    rst = 1'b1;
    tx_busy = 1'b0;
    busy_fixed = 0;
    busy_left = 0;
    n_starts = 0;
    to_seen = 0;
    m_ptr = 0;
    skip_hold = 1'b0;
    held_data = 8'h00;
    clear_srcs();
    repeat (3) tick();
    check_reset_vals("reset");
    rst = 1'b0;

    // Single source, three bytes, long frames.
    busy_fixed = 20;
    s0 = n_starts;
    push_byte(0, 8'hA1, 1'b0);
    push_byte(0, 8'hA2, 1'b0);
    push_byte(0, 8'hA3, 1'b1);
    build_expected();
    drain("single", 400);
    chk("single_starts", n_starts - s0, 3);

    // Contention: all four sources with 6-byte messages.
    do_reset();
    busy_fixed = 0;
    owner_log.delete();
    for (int r = 0; r < NREQ; r++)
      for (int b = 0; b < 6; b++) push_byte(r, 8'($urandom), b == 5);
    build_expected();
    drain("contention", 1000);
    chk("contention_len", owner_log.size(), 24);
    chk("contention_o0", owner_log[0], 0);
    chk("contention_o0_end", owner_log[3], 0);
    chk("contention_o1", owner_log[4], 1);
    chk("contention_o2", owner_log[8], 2);
    chk("contention_o3", owner_log[12], 3);
    chk("contention_o0_again", owner_log[16], 0);

    // Fairness: owner 2 finishes while 1 and 3 wait.
    do_reset();
    push_byte(1, 8'h10, 1'b1);
    build_expected();
    drain("fair_pre", 200);
    owner_log.delete();
    push_byte(1, 8'h11, 1'b1);
    push_byte(2, 8'h22, 1'b1);
    push_byte(3, 8'h33, 1'b1);
    build_expected();
    drain("fair", 300);
    chk("fair_first", owner_log[0], 2);
    chk("fair_next", owner_log[1], 3);
    chk("fair_last", owner_log[2], 1);

    // Randomised traffic.
    for (int s = 0; s < 10; s++) begin
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 3) != 0) begin
          nmsg = int'($urandom_range(1, 2));
          for (int m = 0; m < nmsg; m++) begin
            len = int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
          end
        end
      end
      build_expected();
      drain("random", 1500);
      clear_srcs();
      if (s == 4) do_reset();
    end

    // Reset in the middle of a frame.
    busy_fixed = 20;
    s0 = n_starts;
    push_byte(0, 8'h5C, 1'b0);
    push_byte(0, 8'h5D, 1'b1);
    build_expected();
    k = 0;
    while (n_starts == s0 && k < 30) begin
      tick();
      k++;
    end
    chk("midreset_started", n_starts - s0, 1);
    repeat (3) tick();
    clear_srcs();
    skip_hold = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0;
    check_reset_vals("midreset");
    owner_log.delete();
    push_byte(2, 8'h5A, 1'b1);
    build_expected();
    k = 0;
    while (tx_busy && k < 40) begin
      tick();
      k++;
      if (tx_busy) chk("ready_while_busy", req_ready, 0);
    end
    drain("midreset", 200);
    chk("midreset_owner", owner_log[0], 2);

    // Owner goes quiet after one non-final byte.
    busy_fixed = 20;
    to_seen = 0;
    s0 = n_starts;
    push_byte(1, 8'h77, 1'b0);
    build_expected();
    k = 0;
    while (n_starts == s0 && k < 30) begin
      tick();
      k++;
    end
    chk("to_started", n_starts - s0, 1);
    k = 0;
    while (tx_busy && k < 40) begin
      tick();
      k++;
    end
    k = 0;
    while (to_seen == 0 && k < 60) begin
      tick();
      k++;
    end
`ifdef UART_ARB_TIMEOUT_EN
    chk("timeout_cycle", k, 16);
    tick();
    chk("timeout_pulse_len", timeout_err, 0);
    chk("timeout_grant", grant, 0);
    chk("timeout_total", to_seen, 1);
`else
    chk("no_timeout", to_seen, 0);
    chk("grant_held", grant, 4'b0010);
    chk("grant_id_held", grant_id, 1);
`endif
    do_reset();
    check_reset_vals("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one byte-wide UART transmitter among NREQ byte sources. A granted requester keeps ownership for a burst of up to BURST bytes, or until it flags its last byte. The block issues one start pulse per byte to the transmitter and waits for the transmitter's busy window to close before accepting the next byte. It sits between packet sources (RX buffer echo, status reporters) and the UART TX bit engine.

## Interface
Parameters:
- NREQ, 4, number of requesters; legal range 2..8
- BURST, 4, maximum bytes per grant; legal range 1..15
- TIMEOUT, 12500, idle-owner release limit in clk cycles (10 bit-times at 12 MHz / 9600 baud)

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  requester i presents a byte
- req_data  in  8*NREQ  byte of requester i on [8i+7:8i]
- req_last  in  NREQ  presented byte is the final byte of its message
- req_ready  out  NREQ  one-hot; a byte is accepted on a cycle with valid&ready
- grant  out  NREQ  one-hot current owner; 0 when idle
- grant_id  out  3  binary index of owner; 0 when idle
- tx_start  out  1  one-cycle pulse to UART TX
- tx_data  out  8  byte to send; stable from tx_start until tx_busy falls
- tx_busy  in  1  UART TX frame in progress
- timeout_err  out  1  one-cycle pulse on timeout release

## Operation
- State machine: IDLE, GRANT, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE: if any req_valid is set, select the first set bit searching upward from ptr and wrapping modulo NREQ. Register grant/grant_id, clear byte_cnt, go to GRANT. If no request is present, stay in IDLE.
- GRANT: req_ready[grant_id] = 1 iff tx_busy==0; all other ready bits are 0. On an accepted byte: tx_data <= byte, store last_flag <= req_last[grant_id], go to ISSUE. With valid low, hold state.
- ISSUE: tx_start = 1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: on tx_busy==1 go to WAIT_DONE.
- WAIT_DONE: on tx_busy==0:
  - If last_flag is set or byte_cnt==BURST-1: go to IDLE, clear grant, set ptr <= grant_id+1 mod NREQ.
  - Otherwise: byte_cnt++ and go to GRANT.
- byte_cnt is 4 bits and never exceeds BURST-1. ptr is 3 bits and always holds a value < NREQ.
- Requests in IDLE are sampled only from req_valid. req_last on a non-accepted cycle is ignored.
- Dropping valid while in GRANT causes no state change; ownership is kept.

## Timing
- Reset values: state IDLE, grant 0, grant_id 0, req_ready 0, tx_start 0, tx_data 8'h00, timeout_err 0, ptr 0, byte_cnt 0.
- Request to grant: grant rises 1 cycle after req_valid is sampled in IDLE.
- Accept to start: if the byte is accepted at edge t, tx_start is high in the cycle after t.
- Release to next grant: 1 cycle in WAIT_DONE→IDLE, then 1 cycle IDLE→GRANT, so at least 2 cycles between owners.
- Reset mid-frame: the arbiter returns to IDLE immediately. The UART may still be busy. req_ready stays 0 until tx_busy==0, so the in-flight frame is never overlapped.
- Simultaneous requests: round-robin order starting at ptr. After a release, the previous owner has lowest priority.
- BURST=1: every byte releases the grant.

## Configuration
- UART_ARB_TIMEOUT_EN defined:
  - A 14-bit counter clears on entering GRANT and increments each GRANT cycle with req_valid[grant_id]==0.
  - When the counter reaches TIMEOUT-1, the arbiter goes to IDLE, pulses timeout_err for one cycle, and advances ptr as on a normal release.
- Undefined: no counter is built. The owner holds the grant indefinitely while idle. timeout_err is tied 0.

## Test plan
- Single source: req0 sends 3 bytes 8'hA1,8'hA2,8'hA3 with last on A3; model tx_busy high for 20 cycles per byte. Required: 3 tx_start pulses with matching tx_data, then grant returns to 0.
- Contention: req0..req3 all valid continuously with BURST=4. Required: grants in order 0,1,2,3,0, each owner sending exactly 4 bytes.
- Fairness after release: owner 2 finishes while req1 and req3 are pending. Required: the next grant_id is 3.
- Reset mid-frame: assert rst while tx_busy=1. Required: all outputs at reset values next cycle, and req_ready stays 0 until tx_busy falls.
- Timeout (macro defined, TIMEOUT=16): req1 is granted, sends 1 byte, then drops valid. Required: timeout_err pulses 16 cycles into GRANT and grant clears. With the macro undefined, grant remains 1.
